// File: rtl/regs_io_pkg.sv
// Shared constants, address helpers and debounce state encoding for the
// regs_io register file.
package regs_io_pkg;

  localparam int STA_LVL_BIT = 0;
  localparam int STA_EVT_BIT = 1;

  typedef logic [0:0] db_state_t;
  localparam db_state_t DB_IDLE_MATCH = 1'b0;
  localparam db_state_t DB_COUNT      = 1'b1;

  function automatic int addr_swa(input int ngpr);
    return ngpr + 1;
  endfunction

  function automatic int addr_sta(input int ngpr);
    return ngpr + 2;
  endfunction

endpackage

// File: rtl/regs_io_if.sv
// Decoder/ALU side bus of the regs_io register file: one write port and two
// combinational read ports.
interface regs_io_if #(
  parameter int N  = 8,
  parameter int AW = 3
) ();

  logic          w;
  logic [AW-1:0] Waddr;
  logic [N-1:0]  Wdata;
  logic [AW-1:0] Raddr1;
  logic [AW-1:0] Raddr2;
  logic          ren1;
  logic [N-1:0]  Rdata1;
  logic [N-1:0]  Rdata2;

  modport master (
    output w, Waddr, Wdata, Raddr1, Raddr2, ren1,
    input  Rdata1, Rdata2
  );

  modport slave (
    input  w, Waddr, Wdata, Raddr1, Raddr2, ren1,
    output Rdata1, Rdata2
  );

endinterface

// File: rtl/regs_io_sw_debounce.sv
// Two-flop synchroniser followed by a whole-vector debouncer: a new value is
// accepted only after DEB_CYCLES consecutive matching samples.
module sw_debounce
  import regs_io_pkg::*;
#(
  parameter int W          = 9,
  parameter int DEB_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw_i,
  output logic [W-1:0] stable_o
);

  localparam int            CW       = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [W-1:0]  s1_q, s2_q, cand_q, stable_q;
  logic [CW-1:0] cnt_q;
  db_state_t     state;

  always_comb state = (cnt_q == CNT_LAST) ? DB_IDLE_MATCH : DB_COUNT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q     <= '0;
      s2_q     <= '0;
      cand_q   <= '0;
      stable_q <= '0;
      cnt_q    <= '0;
    end else begin
      s1_q <= sw_i;
      s2_q <= s1_q;
      // The counter saturates at CNT_LAST; any mismatch restarts it.
      if (s2_q != cand_q) begin
        cand_q <= s2_q;
        cnt_q  <= '0;
      end else if (state == DB_IDLE_MATCH) begin
        stable_q <= cand_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/regs_io.sv
// picoMIPS register file: NGPR GPRs, zero register, debounced switch data and
// status registers, registered LED output. REGS_IO_BYPASS_EN enables forwarding.
module regs_io
  import regs_io_pkg::*;
#(
  parameter int N          = 8,
  parameter int NGPR       = 4,
  parameter int AW         = 3,
  parameter int LED_IDX    = 4,
  parameter int DEB_CYCLES = 4
) (
  input  logic         clk,
  input  logic         nReset,
  regs_io_if.slave     bus,
  input  logic [N:0]   SW,
  output logic [N-1:0] out,
  output logic         sw_evt
);

  localparam logic [AW-1:0] SWA      = AW'(addr_swa(NGPR));
  localparam logic [AW-1:0] STA      = AW'(addr_sta(NGPR));
  localparam logic [AW-1:0] LED_A    = AW'(LED_IDX);
  localparam logic [AW-1:0] GPR_LAST = AW'(NGPR);
  localparam int unsigned   NGPR_U   = NGPR;
  localparam int unsigned   NADDR    = 1 << AW;

  logic [N-1:0] gpr_q [1:NGPR];
  logic [N-1:0] out_q, out_d;
  logic         evt_q, evt_d, lvl_q;
  logic [N:0]   stable;
  logic [N-1:0] status;
  logic [N-1:0] rmap [0:NADDR-1];
  logic         we;

  sw_debounce #(
    .W          (N + 1),
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk      (clk),
    .rst_n    (nReset),
    .sw_i     (SW),
    .stable_o (stable)
  );

  assign we = bus.w && (bus.Waddr != '0) && (bus.Waddr <= GPR_LAST);

  always_comb out_d = (we && bus.Waddr == LED_A) ? bus.Wdata : gpr_q[LED_IDX];

  // Set has priority over the clearing read so no button event is lost.
  always_comb begin
    evt_d = evt_q;
    if (bus.ren1 && bus.Raddr1 == STA) evt_d = 1'b0;
    if (stable[N] && !lvl_q)           evt_d = 1'b1;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int unsigned i = 1; i <= NGPR_U; i++) gpr_q[i] <= '0;
      out_q <= '0;
      evt_q <= 1'b0;
      lvl_q <= 1'b0;
    end else begin
      for (int unsigned i = 1; i <= NGPR_U; i++)
        if (we && bus.Waddr == AW'(i)) gpr_q[i] <= bus.Wdata;
      out_q <= out_d;
      evt_q <= evt_d;
      lvl_q <= stable[N];
    end
  end

  always_comb begin
    status              = '0;
    status[STA_LVL_BIT] = stable[N];
    status[STA_EVT_BIT] = evt_q;
  end

  always_comb begin
    for (int unsigned i = 0; i < NADDR; i++) rmap[i] = '0;
    for (int unsigned i = 1; i <= NGPR_U; i++) rmap[i] = gpr_q[i];
    rmap[SWA] = stable[N-1:0];
    rmap[STA] = status;
  end

`ifdef REGS_IO_BYPASS_EN
  assign bus.Rdata1 = (we && bus.Waddr == bus.Raddr1) ? bus.Wdata : rmap[bus.Raddr1];
  assign bus.Rdata2 = (we && bus.Waddr == bus.Raddr2) ? bus.Wdata : rmap[bus.Raddr2];
`else
  assign bus.Rdata1 = rmap[bus.Raddr1];
  assign bus.Rdata2 = rmap[bus.Raddr2];
`endif

  assign out    = out_q;
  assign sw_evt = evt_q;

endmodule

// File: doc/regs_io.md
Name: regs_io

Overview:
- Parametrised picoMIPS register file with integrated I/O registers.
- Holds NGPR general-purpose registers plus a hard-wired zero register, a debounced switch-data register and a switch-status register with a sticky event flag.
- Has a dedicated write address and a registered LED output.
- Sits between the decoder/ALU and the board switches/LEDs; replaces the fixed 4-GPR file.

Parameters:
- N, 8, data bus width.
- NGPR, 4, number of general-purpose registers (1..2**AW-3).
- AW, 3, register address width.
- LED_IDX, 4, register address whose contents drive the LED output (1..NGPR).
- DEB_CYCLES, 4, consecutive stable cycles required to accept a switch change (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- nReset  in  1  asynchronous active-low reset.
- w  in  1  write enable.
- Waddr  in  AW  write register address.
- Wdata  in  N  write data.
- Raddr1  in  AW  read address, port 1.
- Raddr2  in  AW  read address, port 2.
- ren1  in  1  read strobe for port 1; clears the sticky flag when reading the status address.
- SW  in  N+1  raw switches: SW[N-1:0] data, SW[N] button; asynchronous to clk.
- Rdata1  out  N  read data, port 1 (combinational).
- Rdata2  out  N  read data, port 2 (combinational).
- out  out  N  LED register, registered.
- sw_evt  out  1  sticky button-rising-edge flag.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low on nReset.
- Reset values: all GPRs, out, sw_evt, both sync stages, candidate, stable value and debounce counter are 0.
- Address map:
  - 0 reads as zero.
  - 1..NGPR are GPRs.
  - SWA = NGPR+1 reads the debounced data, stable[N-1:0].
  - STA = NGPR+2 reads status: {0..., sw_evt, stable[N]}, with bit0 = button level and bit1 = sw_evt.
  - Higher addresses read 0.
  - SWA and STA are readable on both ports.
- Writes:
  - Apply on the rising clk edge when w=1 and 1<=Waddr<=NGPR.
  - Writes to 0, SWA, STA or unmapped addresses are ignored: no wrap, no aliasing.
- Reads: combinational from the current state, so a write is visible the cycle after its edge (unless BYPASS_EN is defined).
- LED output: out <= (GPR[LED_IDX] next value), so out follows a write to LED_IDX on the same edge the GPR updates.
- Switch path:
  - 2-flop synchroniser s1 -> s2 on all N+1 bits.
  - Debounce FSM over the whole vector:
    - If s2 != cand: cand <= s2, cnt <= 0.
    - Else if cnt == DEB_CYCLES-1: stable <= cand, cnt holds.
    - Else cnt++.
  - A change held steady appears on stable after exactly 3+DEB_CYCLES rising edges (7 at default).
  - Any bounce shorter than this restarts the count; stable never takes a transient value.
- Sticky flag:
  - sw_evt sets on an edge where stable[N] goes 0->1.
  - It clears on an edge where ren1=1 and Raddr1==STA.
  - Simultaneous set and clear: set wins, so no event is lost.
  - Rdata1 during the clearing read shows the pre-clear value (1).
- Reset mid-operation: everything returns to reset values immediately; debounce restarts from 0.
- Width rule: stable[N-1:0] and the status word are zero-extended/truncated to N bits; cnt width is $clog2(DEB_CYCLES)+1.

Optional Feature:
- Macro REGS_IO_BYPASS_EN.
- Defined: if w=1, Waddr==RaddrX and Waddr is a writable GPR, RdataX = Wdata in the same cycle (write-read forwarding on both ports). Forwarding is not applied to 0, SWA, STA or unmapped addresses.
- Undefined: reads return the stored value; the new value appears the cycle after the write edge.

Decomposition:
- Package regs_io_pkg:
  - function addr_swa(NGPR) and function addr_sta(NGPR).
  - localparams STA_LVL_BIT=0 and STA_EVT_BIT=1.
  - typedef for the debounce FSM state {DB_IDLE_MATCH, DB_COUNT}, used for readable waveforms.
- Sub-module sw_debounce (parameters W, DEB_CYCLES): synchroniser, candidate and counter; outputs stable[W-1:0]. Instanced with W=N+1.

Test Plan:
- Reset: assert nReset=0 mid-write of 8'hA5 to %4 -> out=0, all reads 0, sw_evt=0; after release Rdata1(%4)=0.
- GPR write/read: w=1, Waddr=2, Wdata=8'h3C -> next cycle Rdata2(%2)=8'h3C. Write Waddr=0, 5 and 6 -> reads of %0=0, SWA/STA unchanged. Write %4=8'h81 -> out=8'h81 after that edge.
- Debounce: SW[7:0] from 0 to 8'h5A held -> Rdata1(%5)=8'h5A after exactly 7 edges, 0 at edge 6. Toggle the same bit for 3 cycles then revert -> %5 never changes.
- Sticky flag: SW[8] 0->1 held -> sw_evt=1 at edge 8, Rdata1(%6)=8'h03. Release SW[8] -> %6 reads 8'h02. ren1=1, Raddr1=6 -> flag 0 next cycle.
- Set/clear race: a debounced SW[8] rising edge coincides with a clearing read -> sw_evt stays 1.
- Bypass (REGS_IO_BYPASS_EN defined): w=1, Waddr=3, Raddr1=3, Wdata=8'hE7 -> Rdata1=8'hE7 in the same cycle. With the macro undefined -> old value, then 8'hE7 next cycle.
